// File: rtl/rob_pkg.sv
// Shared types and constants for the superscalar reorder buffer.
package rob_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ROB_NO_DEST = 5'd0;

    // Control part of an entry; result values live in a separate non-reset array.
    typedef struct packed {
        logic                 valid;
        logic                 complete;
        logic                 has_dest;
        logic [REG_IDX_W-1:0] dest;
    } rob_entry_t;

    function automatic int tag_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rob_if.sv
// Dispatch / CDB / look-up / retire / squash bundle of the reorder buffer.
interface rob_if
    import rob_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DP_W  = 2,
    parameter int RT_W  = 2,
    parameter int CDB_W = 2,
    parameter int XLEN  = 32
);
    localparam int TAG_W = tag_w(DEPTH);

    logic [DP_W-1:0]              dp_valid;
    logic [DP_W-1:0]              dp_has_dest;
    logic [DP_W*REG_IDX_W-1:0]    dp_dest;
    logic [DP_W-1:0]              dp_is_store;
    logic [TAG_W:0]               dp_free;
    logic [DP_W*TAG_W-1:0]        dp_tag;
    logic [CDB_W-1:0]             cdb_valid;
    logic [CDB_W*TAG_W-1:0]       cdb_tag;
    logic [CDB_W*XLEN-1:0]        cdb_value;
    logic [2*DP_W*TAG_W-1:0]      rd_tag;
    logic [2*DP_W-1:0]            rd_ready;
    logic [2*DP_W*XLEN-1:0]       rd_value;
    logic [RT_W-1:0]              rt_valid;
    logic [RT_W*TAG_W-1:0]        rt_tag;
    logic [RT_W*REG_IDX_W-1:0]    rt_dest;
    logic [RT_W*XLEN-1:0]         rt_value;
    logic                         squash_valid;
    logic [TAG_W-1:0]             squash_tag;
    logic                         empty;

    modport slave (
        input  dp_valid, dp_has_dest, dp_dest, dp_is_store,
        input  cdb_valid, cdb_tag, cdb_value, rd_tag, squash_valid, squash_tag,
        output dp_free, dp_tag, rd_ready, rd_value,
        output rt_valid, rt_tag, rt_dest, rt_value, empty
    );

    modport master (
        output dp_valid, dp_has_dest, dp_dest, dp_is_store,
        output cdb_valid, cdb_tag, cdb_value, rd_tag, squash_valid, squash_tag,
        input  dp_free, dp_tag, rd_ready, rd_value,
        input  rt_valid, rt_tag, rt_dest, rt_value, empty
    );

endinterface

// File: rtl/rob_retire_sel.sv
// Head-relative scan: counts leading valid&complete entries (up to RT_W) and their indices.
module rob_retire_sel
    import rob_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int RT_W  = 2,
    parameter int TAG_W = tag_w(DEPTH)
) (
    input  logic [TAG_W-1:0]      head,
    input  logic [DEPTH-1:0]      done,
    output logic [TAG_W:0]        k,
    output logic [RT_W*TAG_W-1:0] idx
);

    logic run;

    always_comb begin
        k   = '0;
        idx = '0;
        run = 1'b1;
        for (int i = 0; i < RT_W; i++) begin
            idx[i*TAG_W +: TAG_W] = head + TAG_W'(i);
            if (run && done[head + TAG_W'(i)]) begin
                k = k + (TAG_W+1)'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_superscalar.sv
// N-wide reorder buffer: in-order allocate, CDB completion, in-order retire, squash rollback.
// Optional build macro ROB_STORE_SERIALIZE_EN: stores dispatch alone, lane 0 only, into an empty ROB.
module rob_superscalar
    import rob_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DP_W  = 2,
    parameter int RT_W  = 2,
    parameter int CDB_W = 2,
    parameter int XLEN  = 32
) (
    input  logic  clock,
    input  logic  reset_n,
    rob_if.slave  bus
);

    localparam int TAG_W = tag_w(DEPTH);
    localparam int CNT_W = TAG_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    rob_entry_t               ent [DEPTH];
    logic [XLEN-1:0]          val [DEPTH];
    logic [TAG_W-1:0]         head, tail;
    logic [CNT_W-1:0]         count, free, acc, k;
    logic [DEPTH-1:0]         done, kill;
    logic [CDB_W-1:0]         cdb_hit;
    logic [RT_W*TAG_W-1:0]    rt_idx;
    logic [TAG_W-1:0]         n_kill, sq_low;
    logic [CNT_W-1:0]         sq_count;
    logic [DP_W*TAG_W-1:0]    dp_tag_c;
    logic [2*DP_W-1:0]        rd_ready_c;
    logic [2*DP_W*XLEN-1:0]   rd_value_c;

    logic [RT_W-1:0]             rt_valid_p1;
    logic [RT_W*TAG_W-1:0]       rt_tag_p1;
    logic [RT_W*REG_IDX_W-1:0]   rt_dest_p1;
    logic [RT_W*XLEN-1:0]        rt_value_p1;

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            done[j] = ent[j].valid & ent[j].complete;
        end
    end

    rob_retire_sel #(.DEPTH(DEPTH), .RT_W(RT_W), .TAG_W(TAG_W)) u_retire_sel (
        .head (head),
        .done (done),
        .k    (k),
        .idx  (rt_idx)
    );

`ifdef ROB_STORE_SERIALIZE_EN
    logic stop;
`else
    logic dp_is_store_unused;
    assign dp_is_store_unused = ^bus.dp_is_store;
`endif

    // Lanes are contiguous, so accepting the first `acc` lanes is the whole decision.
    always_comb begin
        free = DEPTH_C - count;
        acc  = '0;
        for (int i = 0; i < DP_W; i++) begin
            if (bus.dp_valid[i]) acc = acc + CNT_W'(1);
        end
        if (acc > free) acc = free;
`ifdef ROB_STORE_SERIALIZE_EN
        stop = 1'b0;
        for (int i = 0; i < DP_W; i++) begin
            if (!stop && (CNT_W'(i) < acc) && bus.dp_is_store[i]) begin
                stop = 1'b1;
                acc  = (i == 0 && count == '0) ? CNT_W'(1) : CNT_W'(i);
            end
        end
`endif
        for (int i = 0; i < DP_W; i++) begin
            dp_tag_c[i*TAG_W +: TAG_W] = tail + TAG_W'(i);
        end
    end

    // Squash keeps head..squash_tag; a zero low count means the ring stays full.
    always_comb begin
        n_kill   = tail - bus.squash_tag - TAG_W'(1);
        sq_low   = bus.squash_tag - head + TAG_W'(1);
        sq_count = (sq_low == '0) ? DEPTH_C : {1'b0, sq_low};
        for (int j = 0; j < DEPTH; j++) begin
            kill[j] = ((TAG_W'(j) - bus.squash_tag) != '0) &&
                      ((TAG_W'(j) - bus.squash_tag) <= n_kill);
        end
        for (int p = 0; p < CDB_W; p++) begin
            cdb_hit[p] = bus.cdb_valid[p] && ent[bus.cdb_tag[p*TAG_W +: TAG_W]].valid;
        end
    end

    // Operand look-up: a same-cycle CDB hit overrides the stored value; later ports win.
    always_comb begin
        rd_ready_c = '0;
        rd_value_c = '0;
        for (int q = 0; q < 2*DP_W; q++) begin
            if (done[bus.rd_tag[q*TAG_W +: TAG_W]]) begin
                rd_ready_c[q]                = 1'b1;
                rd_value_c[q*XLEN +: XLEN]   = val[bus.rd_tag[q*TAG_W +: TAG_W]];
            end
            for (int p = 0; p < CDB_W; p++) begin
                if (cdb_hit[p] && (bus.cdb_tag[p*TAG_W +: TAG_W] == bus.rd_tag[q*TAG_W +: TAG_W])) begin
                    rd_ready_c[q]              = 1'b1;
                    rd_value_c[q*XLEN +: XLEN] = bus.cdb_value[p*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int p = 0; p < CDB_W; p++) begin
            if (cdb_hit[p]) val[bus.cdb_tag[p*TAG_W +: TAG_W]] <= bus.cdb_value[p*XLEN +: XLEN];
        end
    end

    // p0 -> p1: entry/pointer update and registered retire lanes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int j = 0; j < DEPTH; j++) ent[j] <= '0;
            rt_valid_p1 <= '0;
            rt_tag_p1   <= '0;
            rt_dest_p1  <= '0;
            rt_value_p1 <= '0;
        end else begin
            rt_valid_p1 <= '0;
            rt_tag_p1   <= '0;
            rt_dest_p1  <= '0;
            rt_value_p1 <= '0;
            for (int p = 0; p < CDB_W; p++) begin
                if (cdb_hit[p]) ent[bus.cdb_tag[p*TAG_W +: TAG_W]].complete <= 1'b1;
            end
            if (bus.squash_valid) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (kill[j]) ent[j] <= '0;
                end
                tail  <= bus.squash_tag + TAG_W'(1);
                count <= sq_count;
            end else begin
                for (int i = 0; i < RT_W; i++) begin
                    if (CNT_W'(i) < k) begin
                        ent[rt_idx[i*TAG_W +: TAG_W]].valid    <= 1'b0;
                        ent[rt_idx[i*TAG_W +: TAG_W]].complete <= 1'b0;
                        rt_valid_p1[i]                         <= 1'b1;
                        rt_tag_p1[i*TAG_W +: TAG_W]            <= rt_idx[i*TAG_W +: TAG_W];
                        rt_dest_p1[i*REG_IDX_W +: REG_IDX_W]   <= ent[rt_idx[i*TAG_W +: TAG_W]].has_dest ?
                                                                  ent[rt_idx[i*TAG_W +: TAG_W]].dest : ROB_NO_DEST;
                        rt_value_p1[i*XLEN +: XLEN]            <= val[rt_idx[i*TAG_W +: TAG_W]];
                    end
                end
                for (int i = 0; i < DP_W; i++) begin
                    if (CNT_W'(i) < acc) begin
                        ent[dp_tag_c[i*TAG_W +: TAG_W]] <= '{valid:    1'b1,
                                                             complete: 1'b0,
                                                             has_dest: bus.dp_has_dest[i],
                                                             dest:     bus.dp_dest[i*REG_IDX_W +: REG_IDX_W]};
                    end
                end
                head  <= head + TAG_W'(k);
                tail  <= tail + TAG_W'(acc);
                count <= count + acc - k;
            end
        end
    end

    assign bus.dp_free  = free;
    assign bus.dp_tag   = dp_tag_c;
    assign bus.rd_ready = rd_ready_c;
    assign bus.rd_value = rd_value_c;
    assign bus.rt_valid = rt_valid_p1;
    assign bus.rt_tag   = rt_tag_p1;
    assign bus.rt_dest  = rt_dest_p1;
    assign bus.rt_value = rt_value_p1;
    assign bus.empty    = (count == '0);

    squash_tag_live: assert property (@(posedge clock) disable iff (!reset_n)
        bus.squash_valid |-> ent[bus.squash_tag].valid);

endmodule
